// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared constants and helpers for the parallel-in/serial-out shift register.
//   PISO_DEFAULT_N : default word width
//   cnt_width(n)   : width of a counter that must hold the values 0..n
// ---------------------------------------------------------------------------
package piso_pkg;

    localparam int PISO_DEFAULT_N = 4;

    // A counter that holds 0..n needs $clog2(n+1) bits (n itself must fit).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
// Counts the bits of the captured word that have not been emitted yet.
// A load sets the count to N. Each non-load edge decrements it, and it
// stops at zero.
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   asynchronous, active-low reset
//   load    in   1   reload the count to N on this edge
//   bit_cnt out  CW  bits still to be emitted
//   busy    out  1   high while bit_cnt != 0
// ---------------------------------------------------------------------------
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int N = PISO_DEFAULT_N,
    localparam int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    output logic [CW-1:0] bit_cnt,
    output logic          busy
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= CW'(N);
        end else if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
        end
    end

    assign busy = (bit_cnt != '0);

endmodule : piso_bit_counter

// File: rtl/piso_shift_reg.sv
// ---------------------------------------------------------------------------
// piso_shift_reg
// N-bit parallel-in/serial-out shift register. A load edge captures
// parallel_in. Every other edge shifts one position toward the output end.
// The output bit is taken straight from shift_reg, so the first bit is
// visible right after the load edge.
//
// There is no valid/ready handshake. The register shifts freely whenever
// load is low. The downstream side samples serial_out once per clock, and
// busy/bit_cnt report how many bits of the current word remain.
//
// Parameters:
//   N          word width (N >= 2)
//   MSB_FIRST  1: shift toward MSB, serial_out = shift_reg[N-1]
//              0: shift toward LSB, serial_out = shift_reg[0]
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous, active-low reset
//   load         in   1   capture parallel_in on this edge
//   serial_in    in   1   fill bit for chaining (only with PISO_CHAIN_IN_EN)
//   parallel_in  in   N   word to serialize
//   serial_out   out  1   current output bit
//   busy         out  1   loaded bits remain unsent
//   bit_cnt      out  CW  bits still to be emitted, CW = $clog2(N+1)
// Configuration macro:
//   PISO_CHAIN_IN_EN  when defined, adds serial_in. Each shift fills the
//                     vacated position from serial_in. Otherwise the fill
//                     bit is 0.
// ---------------------------------------------------------------------------
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int N         = PISO_DEFAULT_N,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
`ifdef PISO_CHAIN_IN_EN
    input  logic          serial_in,
`endif
    input  logic [N-1:0]  parallel_in,
    output logic          serial_out,
    output logic          busy,
    output logic [CW-1:0] bit_cnt
);

    logic [N-1:0] shift_reg;
    logic [N-1:0] shifted;
    logic         fill;

`ifdef PISO_CHAIN_IN_EN
    // Daisy-chain: the upstream register's serial_out feeds in here.
    assign fill = serial_in;
`else
    assign fill = 1'b0;
`endif

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted    = {shift_reg[N-2:0], fill};
            assign serial_out = shift_reg[N-1];
        end else begin : g_lsb_first
            assign shifted    = {fill, shift_reg[N-1:1]};
            assign serial_out = shift_reg[0];
        end
    endgenerate

    // Shifting continues after the word has drained. The register then
    // fills entirely with the fill bit, which keeps serial_out at the
    // idle level (or passes chain data through).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= parallel_in;
        end else begin
            shift_reg <= shifted;
        end
    end

    piso_bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .bit_cnt (bit_cnt),
        .busy    (busy)
    );

endmodule : piso_shift_reg

// File: tb/tb_piso_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_reg
// Directed bench for piso_shift_reg (N=4). Two instances share the same
// stimulus: one is MSB-first and one is LSB-first. A vector table covers
// load/shift/hold behaviour. Hand-written sequences cover reset, reload
// while busy, async reset mid-word and (when PISO_CHAIN_IN_EN is defined)
// the serial_in chain fill.
// ---------------------------------------------------------------------------
module tb_piso_shift_reg;

    localparam int N  = 4;
    localparam int CW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          load        = 1'b0;
    logic [N-1:0]  parallel_in = '0;
    logic          serial_in   = 1'b0;

    logic          so_m, busy_m;
    logic [CW-1:0] cnt_m;
    logic          so_l, busy_l;
    logic [CW-1:0] cnt_l;

    piso_shift_reg #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
`ifdef PISO_CHAIN_IN_EN
        .serial_in   (serial_in),
`endif
        .parallel_in (parallel_in),
        .serial_out  (so_m),
        .busy        (busy_m),
        .bit_cnt     (cnt_m)
    );

    piso_shift_reg #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
`ifdef PISO_CHAIN_IN_EN
        .serial_in   (serial_in),
`endif
        .parallel_in (parallel_in),
        .serial_out  (so_l),
        .busy        (busy_l),
        .bit_cnt     (cnt_l)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [N-1:0] word);
        load        = ld;
        parallel_in = word;
        step();
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        load = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          load;
        logic [N-1:0]  pin;
        logic [N-1:0]  sr_m;
        logic          so_m;
        logic          busy;
        logic [CW-1:0] cnt;
        logic [N-1:0]  sr_l;
        logic          so_l;
    } vec_t;

    vec_t vecs[13];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [N-1:0] word;

        // load 1010, drain
        vecs[0]  = '{1'b1, 4'b1010, 4'b1010, 1'b1, 1'b1, 3'd4, 4'b1010, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1, 3'd3, 4'b0101, 1'b1};
        vecs[2]  = '{1'b0, 4'b0000, 4'b1000, 1'b1, 1'b1, 3'd2, 4'b0010, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 3'd1, 4'b0001, 1'b1};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0};
        // load held high: recapture every cycle, no shift
        vecs[5]  = '{1'b1, 4'b0110, 4'b0110, 1'b0, 1'b1, 3'd4, 4'b0110, 1'b0};
        vecs[6]  = '{1'b1, 4'b1001, 4'b1001, 1'b1, 1'b1, 3'd4, 4'b1001, 1'b1};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1, 3'd3, 4'b0100, 1'b0};
        // load 1011 (LSB-first emits 1,1,0,1 then 0)
        vecs[8]  = '{1'b1, 4'b1011, 4'b1011, 1'b1, 1'b1, 3'd4, 4'b1011, 1'b1};
        vecs[9]  = '{1'b0, 4'b0000, 4'b0110, 1'b0, 1'b1, 3'd3, 4'b0101, 1'b1};
        vecs[10] = '{1'b0, 4'b0000, 4'b1100, 1'b1, 1'b1, 3'd2, 4'b0010, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 4'b1000, 1'b1, 1'b1, 3'd1, 4'b0001, 1'b1};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0};

        // ---- reset ----
        serial_in = 1'b0;
        do_reset();
        check("reset_sr_m",   dut_msb.shift_reg, 4'b0000);
        check("reset_sr_l",   dut_lsb.shift_reg, 4'b0000);
        check("reset_so_m",   so_m,   1'b0);
        check("reset_busy_m", busy_m, 1'b0);
        check("reset_cnt_m",  cnt_m,  3'd0);
        check("reset_busy_l", busy_l, 1'b0);

        // ---- table ----
        for (int i = 0; i < 13; i++) begin
            // parallel_in must be ignored on shift edges: feed junk there.
            word = vecs[i].load ? vecs[i].pin : N'($urandom_range(0, 15));
            drive(vecs[i].load, word);
            check($sformatf("vec%0d_sr_m", i), dut_msb.shift_reg, vecs[i].sr_m);
            check($sformatf("vec%0d_so_m", i), so_m,   vecs[i].so_m);
            check($sformatf("vec%0d_busy_m", i), busy_m, vecs[i].busy);
            check($sformatf("vec%0d_cnt_m", i), cnt_m,  vecs[i].cnt);
            check($sformatf("vec%0d_sr_l", i), dut_lsb.shift_reg, vecs[i].sr_l);
            check($sformatf("vec%0d_so_l", i), so_l,   vecs[i].so_l);
            check($sformatf("vec%0d_cnt_l", i), cnt_l,  vecs[i].cnt);
        end

        // ---- reload while busy ----
        drive(1'b1, 4'b1111);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0000);
        check("reload_pre_cnt", cnt_m, 3'd2);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        drive(1'b1, 4'b0001);
        check("reload_cnt", cnt_m, 3'd4);
        check("reload_busy", busy_m, 1'b1);
        for (int k = 0; k < 5; k++) begin
            logic [0:0] e;
            if (k > 0) drive(1'b0, N'($urandom_range(0, 15)));
            e = exp_q.pop_front();
            check($sformatf("reload_so%0d", k), so_m, e);
        end
        check("reload_done_busy", busy_m, 1'b0);

        // ---- async reset mid-word ----
        drive(1'b1, 4'b1100);
        drive(1'b0, 4'b0000);
        check("midrst_pre_sr", dut_msb.shift_reg, 4'b1000);
        check("midrst_pre_busy", busy_m, 1'b1);
        rst = 1'b0;   // 1 time unit after the edge, 4 before the next
        #1;
        check("midrst_sr_m",  dut_msb.shift_reg, 4'b0000);
        check("midrst_busy",  busy_m, 1'b0);
        check("midrst_cnt",   cnt_m,  3'd0);
        check("midrst_so_m",  so_m,   1'b0);
        check("midrst_sr_l",  dut_lsb.shift_reg, 4'b0000);
        step();
        rst = 1'b1;
        drive(1'b0, 4'b0000);
        check("post_rst_sr", dut_msb.shift_reg, 4'b0000);

`ifdef PISO_CHAIN_IN_EN
        // ---- chain fill from serial_in ----
        serial_in = 1'b1;
        drive(1'b1, 4'b0000);
        check("chain_load_sr", dut_msb.shift_reg, 4'b0000);
        begin
            logic [N-1:0] exp_m[4];
            logic [N-1:0] exp_l[4];
            logic         exp_so[4];
            exp_m  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
            exp_l  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
            exp_so = '{1'b0, 1'b0, 1'b0, 1'b1};
            for (int k = 0; k < 4; k++) begin
                drive(1'b0, 4'b0000);
                check($sformatf("chain_sr_m%0d", k), dut_msb.shift_reg, exp_m[k]);
                check($sformatf("chain_so_m%0d", k), so_m, exp_so[k]);
                check($sformatf("chain_sr_l%0d", k), dut_lsb.shift_reg, exp_l[k]);
                check($sformatf("chain_so_l%0d", k), so_l, exp_so[k]);
            end
        end
        serial_in = 1'b0;
`endif

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_piso_shift_reg
